// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, round-constant table and GF(2^8) helpers
// used by the reverse key schedule and its InvMixColumns output stage.
package aes_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        c = 8'h00;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; enough for the 09/0b/0d/0e InvMixColumns terms.
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (b[0] ? a : 8'h00) ^ (b[1] ? x2 : 8'h00) ^
               (b[2] ? x4 : 8'h00) ^ (b[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational byte lookup.
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] subst
);

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign subst = TABLE[8 * (255 - int'(data)) +: 8];

endmodule

// File: rtl/aes128_inv_key_schedule.sv
// Reverse AES-128 key expansion: walks from the last round key back to the cipher key,
// one key per handshake beat. Define AES_EQINV_KEY_EN for equivalent-inverse-cipher keys.
module aes128_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_lastKey,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [127:0] o_roundKey,
    output logic [3:0]   o_roundNumber,
    output logic         o_busy,
    output logic         o_done
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t       state;
    logic [127:0] rawKey;
    logic [3:0]   round;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rotP3, subP3;
    logic [127:0] prevKey;

    assign {w0, w1, w2, w3} = rawKey;
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign rotP3 = {p3[23:0], p3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : gSubWord
        aes_sbox uSbox (
            .data  (rotP3[8*i +: 8]),
            .subst (subP3[8*i +: 8])
        );
    end

    // Undo the forward round-constant XOR of round r while stepping to r-1.
    assign p0 = w0 ^ subP3 ^ {rcon(round), 24'h000000};
    assign prevKey = {p0, p1, p2, p3};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            rawKey  <= '0;
            round   <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        rawKey  <= i_lastKey;
                        round   <= LAST_ROUND;
                        o_valid <= 1'b1;
                        o_busy  <= 1'b1;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (i_ready) begin
                        if (round != 4'd0) begin
                            rawKey <= prevKey;
                            round  <= round - 4'd1;
                        end else begin
                            o_valid <= 1'b0;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AES_EQINV_KEY_EN
    function automatic logic [31:0] invMixWord(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gfMul(a0, 4'he) ^ gfMul(a1, 4'hb) ^ gfMul(a2, 4'hd) ^ gfMul(a3, 4'h9),
                gfMul(a0, 4'h9) ^ gfMul(a1, 4'he) ^ gfMul(a2, 4'hb) ^ gfMul(a3, 4'hd),
                gfMul(a0, 4'hd) ^ gfMul(a1, 4'h9) ^ gfMul(a2, 4'he) ^ gfMul(a3, 4'hb),
                gfMul(a0, 4'hb) ^ gfMul(a1, 4'hd) ^ gfMul(a2, 4'h9) ^ gfMul(a3, 4'he)};
    endfunction

    // Transform only what leaves the block; chaining keeps using rawKey.
    assign o_roundKey = (round != 4'd0 && round != LAST_ROUND)
                      ? {invMixWord(w0), invMixWord(w1), invMixWord(w2), invMixWord(w3)}
                      : rawKey;
`else
    assign o_roundKey = rawKey;
`endif

    assign o_roundNumber = round;

endmodule

// File: tb/tb_aes128_inv_key_schedule.sv
// Scoreboard bench for aes128_inv_key_schedule (FIPS-197 key schedule known answers).
module tb_aes128_inv_key_schedule;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] lastKey;
    logic         ready;
    logic         valid;
    logic [127:0] roundKey;
    logic [3:0]   roundNumber;
    logic         busy;
    logic         done;

    aes128_inv_key_schedule #(.NUM_ROUNDS(10)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_lastKey     (lastKey),
        .i_ready       (ready),
        .o_valid       (valid),
        .o_roundKey    (roundKey),
        .o_roundNumber (roundNumber),
        .o_busy        (busy),
        .o_done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } beat_t;

    beat_t sbQ[$];
    int    total = 0;
    int    bad = 0;
    int    doneCount = 0;
    int    validCnt = 0;
    int    lowCnt = 0;
    bit    monEn = 0;
    bit    doneExp = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] fipsKey(input int r);
        case (r)
            0:  return 128'h2b7e151628aed2a6abf7158809cf4f3c;
            1:  return 128'ha0fafe1788542cb123a339392a6c7605;
            2:  return 128'hf2c295f27a96b9435935807a7359f67f;
            3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
            5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:  return 128'head27321b58dbad2312bf5607f8d292f;
            9:  return 128'hac7766f319fadc2128d12941575c006e;
            default: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        endcase
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] imc(input logic [127:0] k);
        logic [127:0] r;
        logic [7:0] a [4];
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = k[127 - 32*c - 8*j -: 8];
            r[127 - 32*c -: 32] = {
                gm(a[0], 8'h0e) ^ gm(a[1], 8'h0b) ^ gm(a[2], 8'h0d) ^ gm(a[3], 8'h09),
                gm(a[0], 8'h09) ^ gm(a[1], 8'h0e) ^ gm(a[2], 8'h0b) ^ gm(a[3], 8'h0d),
                gm(a[0], 8'h0d) ^ gm(a[1], 8'h09) ^ gm(a[2], 8'h0e) ^ gm(a[3], 8'h0b),
                gm(a[0], 8'h0b) ^ gm(a[1], 8'h0d) ^ gm(a[2], 8'h09) ^ gm(a[3], 8'h0e)};
        end
        return r;
    endfunction

    function automatic logic [127:0] expKey(input int r);
`ifdef AES_EQINV_KEY_EN
        if (r != 0 && r != 10) return imc(fipsKey(r));
`endif
        return fipsKey(r);
    endfunction

    // Beat is taken at the following rising edge whenever valid and ready are both high here.
    always @(negedge clk) begin
        beat_t e;
        if (monEn && !rst) begin
            chk("done", 128'(done), 128'(doneExp));
            doneExp = 1'b0;
            if (done) doneCount++;
            if (!valid) lowCnt++;
            if (valid) begin
                validCnt++;
                if (sbQ.size() == 0) begin
                    chk("unexpectedBeat", 128'(roundNumber), 128'hf);
                end else if (ready) begin
                    e = sbQ.pop_front();
                    chk("roundNumber", 128'(roundNumber), 128'(e.rnd));
                    chk("roundKey", roundKey, e.key);
                    if (e.rnd == 4'd0) doneExp = 1'b1;
                end else begin
                    chk("heldNumber", 128'(roundNumber), 128'(sbQ[0].rnd));
                    chk("heldKey", roundKey, sbQ[0].key);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushRun();
        beat_t b;
        for (int r = 10; r >= 0; r--) begin
            b.rnd = 4'(r);
            b.key = expKey(r);
            sbQ.push_back(b);
        end
    endtask

    task automatic waitDone(input string tag);
        int snap;
        snap = doneCount;
        for (int i = 0; i < 200 && doneCount == snap; i++) tick();
        chk(tag, 128'(doneCount - snap), 128'd1);
    endtask

    task automatic startRun();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        lastKey = fipsKey(10);
        tick();
        tick();
        chk("rstValid", 128'(valid), 128'd0);
        chk("rstBusy", 128'(busy), 128'd0);
        chk("rstDone", 128'(done), 128'd0);
        chk("rstKey", roundKey, 128'd0);
        chk("rstRound", 128'(roundNumber), 128'd0);
        rst = 1'b0;
        monEn = 1'b1;

        // Straight run at full rate.
        validCnt = 0;
        pushRun();
        startRun();
        chk("busyRun", 128'(busy), 128'd1);
        waitDone("t1Done");
        chk("t1Left", 128'(sbQ.size()), 128'd0);
        chk("t1Valid", 128'(validCnt), 128'd11);
        chk("t1Busy", 128'(busy), 128'd0);

        // Back-pressure for three cycles at round 9.
        validCnt = 0;
        pushRun();
        startRun();
        tick();
        ready = 1'b0;
        repeat (3) tick();
        ready = 1'b1;
        waitDone("t2Done");
        chk("t2Left", 128'(sbQ.size()), 128'd0);
        chk("t2Valid", 128'(validCnt), 128'd14);

        // Stray start with another key during round 5 is ignored.
        pushRun();
        startRun();
        repeat (5) tick();
        lastKey = 128'h00112233445566778899aabbccddeeff;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone("t3Done");
        chk("t3Left", 128'(sbQ.size()), 128'd0);
        lastKey = fipsKey(10);

        // Asynchronous reset mid-run.
        pushRun();
        startRun();
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t4Valid", 128'(valid), 128'd0);
        chk("t4Busy", 128'(busy), 128'd0);
        sbQ.delete();
        begin
            int snap;
            snap = doneCount;
            tick();
            tick();
            rst = 1'b0;
            repeat (3) tick();
            chk("t4NoDone", 128'(doneCount - snap), 128'd0);
        end
        pushRun();
        startRun();
        waitDone("t4Restart");
        chk("t4Left", 128'(sbQ.size()), 128'd0);

        // Start held high across the final beat: one idle cycle between runs.
        validCnt = 0;
        pushRun();
        pushRun();
        start = 1'b1;
        tick();
        lowCnt = 0;
        waitDone("t5Done1");
        start = 1'b0;
        waitDone("t5Done2");
        chk("t5Gap", 128'(lowCnt), 128'd2);
        chk("t5Valid", 128'(validCnt), 128'd22);
        chk("t5Left", 128'(sbQ.size()), 128'd0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
